muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Sits directly downstream of the register file: consumes the rs1/rs2 read data (oREG_OUT1/oREG_OUT2) plus the destination index.
- Produces the result and destination index for the write-back path (iREG_IN/iRD).
- Multi-cycle; the core stalls while oBUSY is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count for the shift-add and restoring-divide loops; must equal XLEN.

Ports:
- iCLK  input  1  clock; all state updates on the rising edge.
- iRST  input  1  reset, synchronous, active-high.
- iSTART  input  1  start request; sampled in IDLE only.
- iFUNCT3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- iRS1_DATA  input  32  dividend / multiplicand.
- iRS2_DATA  input  32  divisor / multiplier.
- iRD  input  5  destination register index, captured at start.
- oBUSY  output  1  high from the cycle after an accepted start until DONE is left.
- oDONE  output  1  one-cycle result-valid pulse.
- oRD  output  5  captured destination index; valid with oDONE, then held.
- oRESULT  output  32  result; valid with oDONE, then held until the next oDONE.

Behaviour:
- Reset (iRST=1 at an edge): state IDLE; oBUSY=0, oDONE=0, oRD=0, oRESULT=0; internal accumulator, counter and latched operands cleared. Applies at any time, including mid-CALC. An aborted operation produces no oDONE.
- States: IDLE, CALC, DONE.
- IDLE -> CALC when iSTART=1 at edge N:
  - latch funct3, iRD, operand sign flags, and absolute values (signed ops only);
  - counter=0; oBUSY=1 from N+1.
- IDLE -> DONE directly (oDONE at N+1) for special cases:
  - divisor==0: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU result=dividend.
  - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: DIV result=0x80000000; REM result=0.
- CALC, one iteration per cycle, counter increments each cycle:
  - multiply: 64-bit shift-add on magnitudes.
  - divide: restoring, 1 quotient bit/cycle; remainder register 33 bits.
  - After iteration ITER-1 (counter==31) -> DONE; oDONE at N+33.
- DONE, exactly one cycle:
  - sign-correct the result: negate the 64-bit product if operand signs differ (MULHSU treats rs2 as unsigned); quotient sign = sign1 XOR sign2; remainder sign = dividend sign.
  - select low 32 bits (MUL) or high 32 bits (MULH*) of the product, or quotient/remainder;
  - register into oRESULT/oRD; oDONE=1; then -> IDLE with oBUSY=0 in the same transition.
- Back-to-back: iSTART in the cycle after oDONE is accepted, because the state is then IDLE.
- iSTART while state≠IDLE is ignored; the in-flight operands are unaffected.
- Operand inputs are don't-care after the start edge.
- oRESULT and oRD never change except on a DONE entry or reset.
- No $display in synthesizable paths.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL* ops compute a full 64-bit signed/unsigned product combinationally at start and go IDLE -> DONE; oDONE at N+1.
  - Division is unchanged (33-cycle).
- Undefined:
  - Iterative multiply, 33-cycle latency; no hardware multiplier inferred.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 localparams (F3_MUL..F3_REMU);
  - state encoding (S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2);
  - XLEN constant;
  - special-case constants (DIV0_Q=32'hFFFFFFFF, INT_MIN=32'h80000000).
- One sub-module: muldiv_signfix, combinational:
  - inputs: raw 64-bit product / quotient / remainder, sign flags, funct3;
  - output: the final 32-bit result.
- FSM, counter and datapath registers stay in muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), iRD=5, start at edge N -> oBUSY high N+1..N+33, oDONE only at N+33, oRESULT=0xFFFFFFEB, oRD=5.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each oDONE at N+33.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; each oDONE at N+1.
- Start DIV, pulse iSTART with new operands at N+5 -> ignored, original result delivered. Assert iRST at N+10 -> next cycle oBUSY=0, oRESULT=0, and no oDONE ever fires for that op.
- With MULDIV_FAST_MUL_EN: MUL 0x12345678×0x10 -> 0x23456780 with oDONE at N+1. Without it: same value with oDONE at N+33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction and result selection for the multiply/divide unit.
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [2*XLEN-1:0] prod_raw,
  input  logic [XLEN-1:0]   quo_raw,
  input  logic [XLEN-1:0]   rem_raw,
  input  logic              sign1,
  input  logic              sign2,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // Remainder takes the dividend's sign; product and quotient take sign1 ^ sign2.
  always_comb begin
    prod = (sign1 ^ sign2) ? (~prod_raw + 64'd1) : prod_raw;
    quo  = (sign1 ^ sign2) ? (~quo_raw + 32'd1) : quo_raw;
    rem  = sign1 ? (~rem_raw + 32'd1) : rem_raw;
    case (funct3)
      F3_MUL:                       result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result = quo;
      default:                      result = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iSTART,
  input  logic [2:0]      iFUNCT3,
  input  logic [XLEN-1:0] iRS1_DATA,
  input  logic [XLEN-1:0] iRS2_DATA,
  input  logic [4:0]      iRD,
  output logic            oBUSY,
  output logic            oDONE,
  output logic [4:0]      oRD,
  output logic [XLEN-1:0] oRESULT
);

  import muldiv_pkg::*;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        sign1_q, sign1_d, sign2_q, sign2_d;
  logic [31:0] op_q, op_d;   // multiplicand or divisor magnitude
  logic [31:0] hi_q, hi_d;   // product high half or partial remainder
  logic [31:0] lo_q, lo_d;   // multiplier/product low half or dividend/quotient
  logic [31:0] res_q, res_d;
  logic [4:0]  out_rd_q, out_rd_d;

  // Start-edge operand decode.
  logic        start_is_div, start_sign1, start_sign2, div_by_zero, div_ovf;
  logic [31:0] abs1, abs2, special_res;

  assign start_is_div = iFUNCT3[2];
  assign start_sign1  = (iFUNCT3 != F3_MULHU) && (iFUNCT3 != F3_DIVU) &&
                        (iFUNCT3 != F3_REMU) && iRS1_DATA[31];
  assign start_sign2  = (iFUNCT3 == F3_MUL || iFUNCT3 == F3_MULH ||
                         iFUNCT3 == F3_DIV || iFUNCT3 == F3_REM) && iRS2_DATA[31];
  assign abs1         = abs_if(iRS1_DATA, start_sign1);
  assign abs2         = abs_if(iRS2_DATA, start_sign2);
  assign div_by_zero  = start_is_div && (iRS2_DATA == 32'd0);
  assign div_ovf      = (iFUNCT3 == F3_DIV || iFUNCT3 == F3_REM) &&
                        (iRS1_DATA == INT_MIN) && (iRS2_DATA == DIV0_Q);
  assign special_res  = div_by_zero ? (iFUNCT3[1] ? iRS1_DATA : DIV0_Q)
                                    : (iFUNCT3[1] ? 32'd0 : INT_MIN);

  // One iteration of either loop, computed from the current registers.
  logic [32:0] mul_sum, trial;
  logic [31:0] iter_hi, iter_lo;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : 33'd0);
    trial   = {hi_q, lo_q[31]} - {1'b0, op_q};
    if (f3_q[2]) begin
      iter_hi = trial[32] ? {hi_q[30:0], lo_q[31]} : trial[31:0];
      iter_lo = {lo_q[30:0], ~trial[32]};
    end else begin
      iter_hi = mul_sum[32:1];
      iter_lo = {mul_sum[0], lo_q[31:1]};
    end
  end

  logic [63:0] fix_prod;
  logic [31:0] fix_quo, fix_rem, fix_result;
  logic        fix_sign1, fix_sign2;
  logic [2:0]  fix_f3;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {32'd0, abs1} * {32'd0, abs2};

  always_comb begin
    if (state_q == S_IDLE) begin
      fix_prod  = fast_prod;
      fix_sign1 = start_sign1;
      fix_sign2 = start_sign2;
      fix_f3    = iFUNCT3;
    end else begin
      fix_prod  = {iter_hi, iter_lo};
      fix_sign1 = sign1_q;
      fix_sign2 = sign2_q;
      fix_f3    = f3_q;
    end
    fix_quo = iter_lo;
    fix_rem = iter_hi;
  end
`else
  always_comb begin
    fix_prod  = {iter_hi, iter_lo};
    fix_quo   = iter_lo;
    fix_rem   = iter_hi;
    fix_sign1 = sign1_q;
    fix_sign2 = sign2_q;
    fix_f3    = f3_q;
  end
`endif

  muldiv_signfix u_signfix (
    .prod_raw (fix_prod),
    .quo_raw  (fix_quo),
    .rem_raw  (fix_rem),
    .sign1    (fix_sign1),
    .sign2    (fix_sign2),
    .funct3   (fix_f3),
    .result   (fix_result)
  );

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    out_rd_d = out_rd_q;
    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          f3_d    = iFUNCT3;
          rd_d    = iRD;
          sign1_d = start_sign1;
          sign2_d = start_sign2;
          cnt_d   = 5'd0;
          hi_d    = 32'd0;
          op_d    = start_is_div ? abs2 : abs1;
          lo_d    = start_is_div ? abs1 : abs2;
          if (div_by_zero || div_ovf) begin
            state_d  = S_DONE;
            res_d    = special_res;
            out_rd_d = iRD;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!start_is_div) begin
            state_d  = S_DONE;
            res_d    = fix_result;
            out_rd_d = iRD;
          end
`endif
          else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hi_d  = iter_hi;
        lo_d  = iter_lo;
        cnt_d = cnt_q + 5'd1;
        // Result is registered on DONE entry so it is valid together with oDONE.
        if (cnt_q == 5'(ITER - 1)) begin
          state_d  = S_DONE;
          res_d    = fix_result;
          out_rd_d = rd_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      f3_q     <= 3'd0;
      rd_q     <= 5'd0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      op_q     <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_q    <= 32'd0;
      out_rd_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      out_rd_q <= out_rd_d;
    end
  end

  assign oBUSY   = (state_q != S_IDLE);
  assign oDONE   = (state_q == S_DONE);
  assign oRESULT = res_q;
  assign oRD     = out_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, special cases, ignore and abort.
module tb_muldiv_unit;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iSTART;
  logic [2:0]  iFUNCT3;
  logic [31:0] iRS1_DATA, iRS2_DATA;
  logic [4:0]  iRD;
  logic        oBUSY, oDONE;
  logic [4:0]  oRD;
  logic [31:0] oRESULT;

  muldiv_unit dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iSTART    (iSTART),
    .iFUNCT3   (iFUNCT3),
    .iRS1_DATA (iRS1_DATA),
    .iRS2_DATA (iRS2_DATA),
    .iRD       (iRD),
    .oBUSY     (oBUSY),
    .oDONE     (oDONE),
    .oRD       (oRD),
    .oRESULT   (oRESULT)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  rd;
    int          done_cyc;
  } sb_entry_t;

  sb_entry_t sb[$];
  int tests = 0;
  int fails = 0;

  // Latency from the start edge to the sampling point where oDONE is seen.
  localparam int LAT_ITER = 32;
  localparam int LAT_FAST = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = LAT_FAST;
`else
  localparam int LAT_MUL = LAT_ITER;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every oDONE pulse must match the oldest outstanding expectation.
  always @(negedge iCLK) begin
    if (!iRST && oDONE) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got result 0x%08h rd %0d with nothing outstanding", oRESULT, oRD);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, oRESULT, e.res);
        check({e.name, "_rd"}, {27'd0, oRD}, {27'd0, e.rd});
        check({e.name, "_latency"}, cyc, e.done_cyc);
      end
    end
  end

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
    @(negedge iCLK);
    iSTART    = 1'b1;
    iFUNCT3   = f3;
    iRS1_DATA = a;
    iRS2_DATA = b;
    iRD       = rd;
    @(posedge iCLK);
    #1;
    iSTART    = 1'b0;
    iRS1_DATA = $urandom;
    iRS2_DATA = $urandom;
    iRD       = 5'($urandom);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) return;
      @(posedge iCLK);
      #2;
    end
    tests++;
    fails++;
    $display("FAIL %s_timeout: got %0d results outstanding expected 0", name, sb.size());
    sb.delete();
  endtask

  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int lat, input bit chk_busy);
    sb_entry_t e;
    drive_start(f3, a, b, rd);
    e.name = name; e.res = exp; e.rd = rd; e.done_cyc = cyc + lat;
    sb.push_back(e);
    if (chk_busy) begin
      check({name, "_busy0"}, {31'd0, oBUSY}, 32'd1);
      for (int k = 1; k <= 33; k++) begin
        @(posedge iCLK);
        #2;
        if (k == 1 || k == 16 || k == 32 || k == 33)
          check($sformatf("%s_busy%0d", name, k), {31'd0, oBUSY}, (k <= 32) ? 32'd1 : 32'd0);
      end
    end
    wait_drain(name);
  endtask

  initial begin
    iRST = 1'b1; iSTART = 1'b0; iFUNCT3 = 3'd0;
    iRS1_DATA = 32'd0; iRS2_DATA = 32'd0; iRD = 5'd0;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_busy",   {31'd0, oBUSY}, 32'd0);
    check("rst_done",   {31'd0, oDONE}, 32'd0);
    check("rst_result", oRESULT, 32'd0);
    check("rst_rd",     {27'd0, oRD}, 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;

    issue("mul_7_m3",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT_MUL, !LAT_MUL[0] && LAT_MUL != 0);
    issue("mul_m2_m3",    3'b000, 32'hFFFF_FFFE,  32'hFFFF_FFFD, 5'd6,  32'd6,         LAT_MUL, 1'b0);
    issue("mulh_min",     3'b001, 32'h8000_0000,  32'h8000_0000, 5'd7,  32'h4000_0000, LAT_MUL, 1'b0);
    issue("mulhu_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, LAT_MUL, 1'b0);
    issue("mulhsu_max",   3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFF, LAT_MUL, 1'b0);
    issue("mul_fast",     3'b000, 32'h1234_5678,  32'h10,        5'd10, 32'h2345_6780, LAT_MUL, 1'b0);
    issue("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFD, LAT_ITER, 1'b1);
    issue("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFF, LAT_ITER, 1'b0);
    issue("div_7_m2",     3'b100, 32'd7,          32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, LAT_ITER, 1'b0);
    issue("rem_m7_m2",    3'b110, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFF, LAT_ITER, 1'b0);
    issue("divu_100_7",   3'b101, 32'd100,        32'd7,         5'd15, 32'd14,        LAT_ITER, 1'b0);
    issue("remu_100_7",   3'b111, 32'd100,        32'd7,         5'd16, 32'd2,         LAT_ITER, 1'b0);
    issue("divu_5_0",     3'b101, 32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF, LAT_FAST, 1'b0);
    issue("remu_5_0",     3'b111, 32'd5,          32'd0,         5'd18, 32'd5,         LAT_FAST, 1'b0);
    issue("div_m7_0",     3'b100, 32'hFFFF_FFF9,  32'd0,         5'd19, 32'hFFFF_FFFF, LAT_FAST, 1'b0);
    issue("rem_m7_0",     3'b110, 32'hFFFF_FFF9,  32'd0,         5'd20, 32'hFFFF_FFF9, LAT_FAST, 1'b0);
    issue("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd21, 32'h8000_0000, LAT_FAST, 1'b0);
    issue("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd22, 32'd0,         LAT_FAST, 1'b0);

    // A second start while busy must be ignored; the original divide completes.
    begin
      sb_entry_t e;
      drive_start(3'b100, 32'd100, 32'd7, 5'd23);
      e.name = "div_ignore"; e.res = 32'd14; e.rd = 5'd23; e.done_cyc = cyc + LAT_ITER;
      sb.push_back(e);
      repeat (4) @(posedge iCLK);
      drive_start(3'b111, 32'd1000, 32'd3, 5'd24);
      wait_drain("div_ignore");
      repeat (3) @(posedge iCLK);
      #2;
      check("ignore_idle_busy", {31'd0, oBUSY}, 32'd0);
      check("ignore_held_result", oRESULT, 32'd14);
    end

    // Reset mid-calculation aborts the operation without an oDONE.
    drive_start(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd25);
    repeat (9) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    check("abort_busy",   {31'd0, oBUSY}, 32'd0);
    check("abort_result", oRESULT, 32'd0);
    check("abort_rd",     {27'd0, oRD}, 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge iCLK);
      if (k % 8 == 0) check($sformatf("abort_no_done%0d", k), {31'd0, oDONE}, 32'd0);
    end

    issue("divu_after_rst", 3'b101, 32'd100, 32'd7, 5'd26, 32'd14, LAT_ITER, 1'b0);

    repeat (5) @(posedge iCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
